de_selector_1to4: RTL and testbench

- Registered 1-to-4 demultiplexer (de-selector).
- Data input iC is steered to one of four outputs oZ0..oZ3, chosen by the 2-bit select {iS1,iS0}.
- Non-selected outputs are driven to a fixed idle value.
- Sits in the datapath wherever one source must be routed to one of four sinks; outputs are registered for clean timing into downstream logic.

---
 rtl/de_selector_pkg.sv | 17 +
 rtl/de_selector_decoder_2to4.sv | 19 +
 rtl/de_selector_1to4.sv | 53 +++++
 tb/tb_de_selector_1to4.sv | 138 +++++++++++++
 4 files changed

// File: rtl/de_selector_pkg.sv
// Shared constants and helpers for the registered 1-to-4 de-selector.
package de_selector_pkg;

   localparam int NUM_OUTS  = 4;
   localparam int MAX_WIDTH = 64;

   localparam logic [1:0] SEL_Z0 = 2'd0;
   localparam logic [1:0] SEL_Z1 = 2'd1;
   localparam logic [1:0] SEL_Z2 = 2'd2;
   localparam logic [1:0] SEL_Z3 = 2'd3;

   // All-ones of the requested width, right-aligned in a MAX_WIDTH word.
   function automatic logic [MAX_WIDTH-1:0] idle_ones(input int width);
      return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
   endfunction

endpackage

// File: rtl/de_selector_decoder_2to4.sv
// Combinational 2-bit select to one-hot 4-bit decoder.
module decoder_2to4
   import de_selector_pkg::*;
(
   input  logic [1:0]          sel,
   output logic [NUM_OUTS-1:0] onehot
);

   always_comb begin
      onehot = '0;
      case (sel)
         SEL_Z0: onehot = 4'b0001;
         SEL_Z1: onehot = 4'b0010;
         SEL_Z2: onehot = 4'b0100;
         SEL_Z3: onehot = 4'b1000;
      endcase
   end

endmodule

// File: rtl/de_selector_1to4.sv
// Registered 1-to-4 demultiplexer: iC routed to one of oZ0..oZ3, the rest idle.
module de_selector_1to4
   import de_selector_pkg::*;
#(
   parameter int               WIDTH    = 1,
   parameter logic [WIDTH-1:0] IDLE_VAL = WIDTH'(idle_ones(WIDTH))
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iEn,
   input  logic [WIDTH-1:0] iC,
   input  logic             iS1,
   input  logic             iS0,
   output logic [WIDTH-1:0] oZ0,
   output logic [WIDTH-1:0] oZ1,
   output logic [WIDTH-1:0] oZ2,
   output logic [WIDTH-1:0] oZ3
);

   logic [1:0]                     sel;
   logic [NUM_OUTS-1:0]            sel_onehot;
   logic [NUM_OUTS-1:0][WIDTH-1:0] z_d;
   logic [NUM_OUTS-1:0][WIDTH-1:0] z_q;

   assign sel = {iS1, iS0};

   decoder_2to4 u_dec (
      .sel    (sel),
      .onehot (sel_onehot)
   );

   // Every enabled edge re-decodes all four outputs, so the old target
   // drops to idle on the same edge the new one picks up iC.
   always_comb begin
      z_d = z_q;
      if (iEn) begin
         for (int n = 0; n < NUM_OUTS; n++) begin
            z_d[n] = sel_onehot[n] ? iC : IDLE_VAL;
         end
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) z_q <= {NUM_OUTS{IDLE_VAL}};
      else      z_q <= z_d;
   end

   assign oZ0 = z_q[0];
   assign oZ1 = z_q[1];
   assign oZ2 = z_q[2];
   assign oZ3 = z_q[3];

endmodule

// File: tb/tb_de_selector_1to4.sv
// Scoreboard bench for de_selector_1to4 at WIDTH=1 and WIDTH=8.
module tb_de_selector_1to4;

   typedef struct packed {
      logic [3:0]      z1;
      logic [3:0][7:0] z8;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst, en, s1, s0;
   logic       c1;
   logic [7:0] c8;
   logic       a0, a1, a2, a3;
   logic [7:0] b0, b1, b2, b3;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb_q[$];

   // reference state: value each output should hold
   logic       m1[4];
   logic [7:0] m8[4];

   always #5 clk = ~clk;

   de_selector_1to4 #(.WIDTH(1)) u_w1 (
      .iClk(clk), .iRst(rst), .iEn(en), .iC(c1), .iS1(s1), .iS0(s0),
      .oZ0(a0), .oZ1(a1), .oZ2(a2), .oZ3(a3)
   );

   de_selector_1to4 #(.WIDTH(8)) u_w8 (
      .iClk(clk), .iRst(rst), .iEn(en), .iC(c8), .iS1(s1), .iS0(s0),
      .oZ0(b0), .oZ1(b1), .oZ2(b2), .oZ3(b3)
   );

   // Drive one cycle of stimulus at the falling edge and queue what the
   // outputs must show after the following rising edge.
   task automatic step(input logic r, input logic e, input logic [1:0] sel,
                       input logic cc1, input logic [7:0] cc8);
      exp_t x;
      @(negedge clk);
      rst = r; en = e; {s1, s0} = sel; c1 = cc1; c8 = cc8;
      for (int m = 0; m < 4; m++) begin
         if (r) begin
            m1[m] = 1'b1;
            m8[m] = 8'hFF;
         end else if (e) begin
            m1[m] = (m == int'(sel)) ? cc1 : 1'b1;
            m8[m] = (m == int'(sel)) ? cc8 : 8'hFF;
         end
      end
      for (int m = 0; m < 4; m++) begin
         x.z1[m] = m1[m];
         x.z8[m] = m8[m];
      end
      sb_q.push_back(x);
   endtask

   initial begin : monitor
      exp_t x;
      logic [3:0]      g1;
      logic [3:0][7:0] g8;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            x  = sb_q.pop_front();
            g1 = {a3, a2, a1, a0};
            g8 = {b3, b2, b1, b0};
            n_cmp++;
            if (g1 !== x.z1) begin
               n_bad++;
               $display("FAIL w1_outputs t=%0t got=%b want=%b", $time, g1, x.z1);
            end
            n_cmp++;
            if (g8 !== x.z8) begin
               n_bad++;
               $display("FAIL w8_outputs t=%0t got=%h want=%h", $time, g8, x.z8);
            end
         end
      end
   end

   initial begin : driver
      int wait_cyc;
      rst = 1'b1; en = 1'b0; s1 = 1'b0; s0 = 1'b0; c1 = 1'b0; c8 = 8'h00;

      // reset held for a few edges while other inputs toggle
      step(1, 0, 2'd0, 0, 8'h00);
      step(1, 1, 2'd2, 0, 8'h12);
      step(1, 1, 2'd1, 1, 8'h00);

      // select sweep with iC=0, then iC=1 (all ones)
      for (int s = 0; s < 4; s++) step(0, 1, 2'(s), 0, 8'h00);
      for (int s = 0; s < 4; s++) step(0, 1, 2'(s), 1, 8'hFF);

      // hold: enable low keeps the last routing
      step(0, 1, 2'd2, 0, 8'h33);
      for (int k = 0; k < 3; k++) step(0, 0, 2'd1, 1, 8'hC4);

      // reset mid-operation beats an enabled update
      step(0, 1, 2'd3, 0, 8'h01);
      step(1, 1, 2'd0, 0, 8'h77);
      step(0, 1, 2'd3, 0, 8'h01);

      // one-edge latency: outputs must still be idle just before the edge
      step(1, 0, 2'd0, 0, 8'h00);
      step(0, 1, 2'd1, 0, 8'h5A);
      #3;
      n_cmp++;
      if (b1 !== 8'hFF) begin
         n_bad++;
         $display("FAIL w8_latency got=%h want=%h", b1, 8'hFF);
      end
      step(0, 1, 2'd1, 0, 8'h5A);

      // randomized traffic
      for (int k = 0; k < 300; k++) begin
         step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
              2'($urandom_range(0, 3)), 1'($urandom), 8'($urandom));
      end

      wait_cyc = 0;
      while (sb_q.size() > 0 && wait_cyc < 10) begin
         @(posedge clk);
         wait_cyc++;
      end
      #2;
      if (sb_q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout left=%0d want=0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
